dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 9 +
 rtl/rr_pick2.sv | 12 +
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;
   typedef enum logic {IDLE = 1'b0, RD_RESP = 1'b1} state_t;
   typedef enum logic {ID_CPU = 1'b0, ID_DBG = 1'b1} req_id_t;
   localparam logic [2:0] ALIGN_MASK = 3'b111;
   function automatic logic misaligned(input logic [2:0] lsb);
      return (lsb & ALIGN_MASK) != 3'b000;
   endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin choice; bit 0 = CPU, bit 1 = DBG, one-hot out.
module rr_pick2
   import dmem_arbiter_pkg::*;
(
   input  logic       cpu_req,
   input  logic       dbg_req,
   input  req_id_t    last_gnt,
   output logic [1:0] gnt
);
   always_comb
      gnt = (cpu_req && dbg_req) ? ((last_gnt == ID_CPU) ? 2'b10 : 2'b01) : {dbg_req, cpu_req};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one registered-read data memory between the CPU and a
// debug/DMA requester with round-robin tie-breaking and misalignment rejection.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_err,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_stall,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   state_t            state, state_nx;
   req_id_t           last_gnt, owner, win_id;
   logic [1:0]        pick, gnt, err_q, err_nx;
   logic              any_gnt, win_we, win_mis, rv;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   rr_pick2 u_pick (
      .cpu_req (cpu_req),
      .dbg_req (dbg_req),
      .last_gnt(last_gnt),
      .gnt     (pick)
   );

   // Grants only in IDLE and never while reset is held.
   always_comb begin
      gnt       = (reset && state == IDLE) ? pick : 2'b00;
      any_gnt   = |gnt;
      win_id    = gnt[1] ? ID_DBG : ID_CPU;
      win_we    = gnt[1] ? dbg_we : cpu_we;
      win_addr  = gnt[1] ? dbg_addr : cpu_addr;
      win_wdata = gnt[1] ? dbg_wdata : cpu_wdata;
      win_mis   = misaligned(win_addr[2:0]);
      mem_read  = any_gnt && !win_we && !win_mis;
      mem_write = any_gnt && win_we && !win_mis;
      mem_addr  = any_gnt ? win_addr : '0;
      mem_wdata = any_gnt ? win_wdata : '0;
      err_nx    = (any_gnt && win_mis) ? gnt : 2'b00;
      state_nx  = mem_read ? RD_RESP : IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         last_gnt <= ID_CPU;
         owner    <= ID_CPU;
         err_q    <= 2'b00;
      end else begin
         state <= state_nx;
         err_q <= err_nx;
         if (any_gnt) last_gnt <= win_id;
         if (mem_read) owner <= win_id;
      end
   end

   // Response is the memory's registered read data, steered to the owner only.
   always_comb begin
      rv         = reset && state == RD_RESP;
      cpu_rvalid = rv && owner == ID_CPU;
      dbg_rvalid = rv && owner == ID_DBG;
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
      cpu_gnt    = gnt[0];
      dbg_gnt    = gnt[1];
      cpu_stall  = cpu_req && !gnt[0];
      dbg_stall  = dbg_req && !gnt[1];
      cpu_err    = err_q[0];
      dbg_err    = err_q[1];
      busy       = state != IDLE;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized requesters against a transaction-level model
// with its own shadow memory; every output is compared every cycle.
module tb_dmem_arbiter;
   logic        clk = 0;
   logic        reset = 0;
   logic        rq [2];
   logic        we [2];
   logic [63:0] ad [2];
   logic [63:0] wd [2];
   logic        cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
   logic        dbg_gnt, dbg_stall, dbg_rvalid, dbg_err;
   logic [63:0] cpu_rdata, dbg_rdata;
   logic        mem_read, mem_write, busy;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [63:0] mem [32];
   logic [63:0] ref_mem [32];
   int          n_chk = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(rq[0]), .cpu_we(we[0]), .cpu_addr(ad[0]), .cpu_wdata(wd[0]),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .dbg_req(rq[1]), .dbg_we(we[1]), .dbg_addr(ad[1]), .dbg_wdata(wd[1]),
      .dbg_gnt(dbg_gnt), .dbg_stall(dbg_stall), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Registered-read memory attached to the DUT's memory port.
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr[7:3]] <= mem_wdata;
      if (mem_read) mem_rdata <= mem[mem_addr[7:3]];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic new_req(input int i);
      rq[i] = 1'b1;
      we[i] = $urandom_range(0, 1) == 1;
      ad[i] = {56'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0};
      wd[i] = {$urandom, $urandom};
   endtask

   initial begin
      int          m_resp, m_last, w, wi;
      logic [1:0]  m_err;
      logic [63:0] m_data;
      logic        mis, e_rd, e_wr;
      int          gcnt [2];
      for (int k = 0; k < 32; k++) begin
         mem[k] = {$urandom, $urandom};
         ref_mem[k] = mem[k];
      end
      mem_rdata = '0;
      for (int i = 0; i < 2; i++) begin
         rq[i] = 0; we[i] = 0; ad[i] = '0; wd[i] = '0; gcnt[i] = 0;
      end
      m_resp = -1; m_last = 0; m_err = 2'b00; m_data = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         w = -1;
         if (reset && m_resp < 0)
            w = (rq[0] && rq[1]) ? (m_last == 0 ? 1 : 0) : rq[0] ? 0 : rq[1] ? 1 : -1;
         wi   = (w < 0) ? 0 : w;
         mis  = (w >= 0) && (ad[wi][2:0] != 3'd0);
         e_rd = (w >= 0) && !we[wi] && !mis;
         e_wr = (w >= 0) && we[wi] && !mis;
         check("cpu_gnt", 64'(cpu_gnt), 64'(w == 0));
         check("dbg_gnt", 64'(dbg_gnt), 64'(w == 1));
         check("cpu_stall", 64'(cpu_stall), 64'(rq[0] && w != 0));
         check("dbg_stall", 64'(dbg_stall), 64'(rq[1] && w != 1));
         check("mem_read", 64'(mem_read), 64'(e_rd));
         check("mem_write", 64'(mem_write), 64'(e_wr));
         check("mem_addr", mem_addr, (w >= 0) ? ad[wi] : 64'd0);
         check("mem_wdata", mem_wdata, (w >= 0) ? wd[wi] : 64'd0);
         check("cpu_rvalid", 64'(cpu_rvalid), 64'(reset && m_resp == 0));
         check("dbg_rvalid", 64'(dbg_rvalid), 64'(reset && m_resp == 1));
         check("cpu_rdata", cpu_rdata, (reset && m_resp == 0) ? m_data : 64'd0);
         check("dbg_rdata", dbg_rdata, (reset && m_resp == 1) ? m_data : 64'd0);
         check("cpu_err", 64'(cpu_err), 64'(m_err[0]));
         check("dbg_err", 64'(dbg_err), 64'(m_err[1]));
         check("busy", 64'(busy), 64'(m_resp >= 0));
         @(posedge clk);
         if (!reset) begin
            m_resp = -1; m_last = 0; m_err = 2'b00;
         end else begin
            m_err  = mis ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
            m_resp = e_rd ? w : -1;
            if (e_rd) m_data = ref_mem[ad[wi][7:3]];
            if (e_wr) ref_mem[ad[wi][7:3]] = wd[wi];
            if (w >= 0) begin
               m_last = w;
               gcnt[w]++;
            end
         end
         #1;
         if (cyc == 2) begin
            reset = 1;
            rq[0] = 1; we[0] = 1; ad[0] = 64'h10; wd[0] = 64'd5;
            rq[1] = 1; we[1] = 1; ad[1] = 64'h18; wd[1] = 64'd7;
         end else if (cyc > 2) begin
            reset = (cyc < 20) || ($urandom_range(0, 39) != 0);
            for (int i = 0; i < 2; i++) begin
               if (w == i) rq[i] = 0;
               else if (rq[i] && $urandom_range(0, 15) == 0) rq[i] = 0;
               if (!rq[i] && $urandom_range(0, 2) != 0) new_req(i);
            end
         end
      end
      check("cpu_served", 64'(gcnt[0] > 100), 64'd1);
      check("dbg_served", 64'(gcnt[1] > 100), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
